// File: rtl/mem_uart_tx.sv
// Reads MEM_SIZE 32-bit words from a synchronous-read memory and streams them
// LSB-first, one byte at a time, to a uart_tx style byte interface.
module mem_uart_tx #(
    parameter int MEM_SIZE = 2,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              tx_dv,
    output logic [7:0]        tx_byte,
    input  logic              tx_done,
    output logic              busy,
    output logic              send_done
);

    // state   | meaning
    // IDLE    | waiting for first start edge since reset
    // FETCH   | mem_addr presents the current word index
    // WAIT_RD | address held while the synchronous read completes
    // LOAD    | read data captured into the shift register
    // SEND    | tx_dv strobe for the current byte
    // WAIT_TX | waiting for uart_tx to finish the byte
    // DONE    | transfer complete, send_done held
    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT_RD, LOAD, SEND, WAIT_TX, DONE
    } state_t;

    localparam logic [ADDR_W:0] WORD_CNT = (ADDR_W+1)'(MEM_SIZE);

    state_t            state_q, state_d;
    logic              start_q, start_d;
    logic              arm_q, arm_d;
    logic [ADDR_W:0]   word_q, word_d, word_inc;
    logic [1:0]        byte_q, byte_d;
    logic [31:0]       shift_q, shift_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              tx_dv_q, tx_dv_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              busy_q, busy_d;
    logic              send_done_q, send_done_d;
    logic              start_edge;

    always_comb begin
        state_d     = state_q;
        start_d     = start;
        // start held high across reset release must drop before an edge counts
        arm_d       = arm_q | ~start;
        word_d      = word_q;
        byte_d      = byte_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        tx_dv_d     = 1'b0;
        tx_byte_d   = tx_byte_q;
        busy_d      = busy_q;
        send_done_d = send_done_q;
        word_inc    = word_q + 1'b1;
        start_edge  = start & ~start_q & arm_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_edge) begin
                    word_d      = '0;
                    byte_d      = '0;
                    addr_d      = '0;
                    send_done_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                addr_d  = word_q[ADDR_W-1:0];
                state_d = WAIT_RD;
            end
            WAIT_RD: state_d = LOAD;
            LOAD: begin
                shift_d   = mem_rdata;
                tx_byte_d = mem_rdata[7:0];
                tx_dv_d   = 1'b1;
                state_d   = SEND;
            end
            SEND: state_d = WAIT_TX;
            WAIT_TX: begin
                if (tx_done) begin
                    shift_d = {8'h00, shift_q[31:8]};
                    byte_d  = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        word_d = word_inc;
                        if (word_inc < WORD_CNT) begin
                            addr_d  = word_inc[ADDR_W-1:0];
                            state_d = FETCH;
                        end else begin
                            busy_d      = 1'b0;
                            send_done_d = 1'b1;
                            state_d     = DONE;
                        end
                    end else begin
                        tx_byte_d = shift_q[15:8];
                        tx_dv_d   = 1'b1;
                        state_d   = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            arm_q       <= 1'b0;
            word_q      <= '0;
            byte_q      <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            tx_dv_q     <= 1'b0;
            tx_byte_q   <= '0;
            busy_q      <= 1'b0;
            send_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            arm_q       <= arm_d;
            word_q      <= word_d;
            byte_q      <= byte_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            tx_dv_q     <= tx_dv_d;
            tx_byte_q   <= tx_byte_d;
            busy_q      <= busy_d;
            send_done_q <= send_done_d;
        end
    end

    assign mem_addr  = addr_q;
    assign tx_dv     = tx_dv_q;
    assign tx_byte   = tx_byte_q;
    assign busy      = busy_q;
    assign send_done = send_done_q;

endmodule

// File: tb/tb_mem_uart_tx.sv
// Bench for mem_uart_tx: serial uart model with receiver feeding a byte
// scoreboard, plus a second small instance with MEM_SIZE=1.
module tb_mem_uart_tx;

    localparam int CPB = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic        tx_dv, tx_done, busy, send_done;
    logic [7:0]  tx_byte;
    logic        tx_done_m, inj_done = 1'b0;

    logic        start1 = 1'b0;
    logic [0:0]  mem_addr1;
    logic [31:0] mem_rdata1;
    logic        tx_dv1, tx_done1, busy1, send_done1;
    logic [7:0]  tx_byte1;

    logic [31:0] mem0 [256];
    logic [31:0] mem1 [2];

    logic [7:0]  q0[$];
    logic [7:0]  q1[$];

    int checks = 0;
    int failures = 0;
    int dv_cnt = 0;
    int sd_rise = 0;
    logic dv_prev = 1'b0, sd_prev = 1'b0;
    logic [7:0] held_byte = 8'h00;

    always #5 clk = ~clk;

    assign tx_done = tx_done_m | inj_done;

    mem_uart_tx #(.MEM_SIZE(2), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .tx_dv(tx_dv), .tx_byte(tx_byte),
        .tx_done(tx_done), .busy(busy), .send_done(send_done)
    );

    mem_uart_tx #(.MEM_SIZE(1), .ADDR_W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mem_addr(mem_addr1),
        .mem_rdata(mem_rdata1), .tx_dv(tx_dv1), .tx_byte(tx_byte1),
        .tx_done(tx_done1), .busy(busy1), .send_done(send_done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) mem_rdata  <= mem0[mem_addr];
    always @(posedge clk) mem_rdata1 <= mem1[mem_addr1];

    // uart_tx model: 10-bit frame, tx_done pulse at end of stop bit
    logic [9:0] u_frame;
    logic [3:0] u_bit;
    int         u_cnt;
    logic       u_busy, tx_serial;
    assign tx_serial = u_busy ? u_frame[u_bit] : 1'b1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            u_busy <= 1'b0; tx_done_m <= 1'b0; u_cnt <= 0; u_bit <= '0; u_frame <= '1;
        end else begin
            tx_done_m <= 1'b0;
            if (!u_busy) begin
                if (tx_dv) begin
                    u_frame <= {1'b1, tx_byte, 1'b0};
                    u_busy <= 1'b1; u_cnt <= 0; u_bit <= '0;
                end
            end else if (u_cnt == CPB-1) begin
                u_cnt <= 0;
                if (u_bit == 4'd9) begin
                    u_busy <= 1'b0; tx_done_m <= 1'b1;
                end else u_bit <= u_bit + 4'd1;
            end else u_cnt <= u_cnt + 1;
        end
    end

    // serial receiver: mid-bit sampling, feeds the scoreboard
    logic       r_busy = 1'b0;
    int         r_cnt = 0;
    logic [7:0] r_sh = 8'h00;
    always @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0; r_cnt <= 0;
        end else if (!r_busy) begin
            if (!tx_serial) begin r_busy <= 1'b1; r_cnt <= 1; end
        end else begin
            r_cnt <= r_cnt + 1;
            if (r_cnt > CPB && r_cnt < 9*CPB && (r_cnt % CPB) == CPB/2)
                r_sh <= {tx_serial, r_sh[7:1]};
            if (r_cnt == 9*CPB + CPB/2) begin
                r_busy <= 1'b0;
                if (q0.size() == 0) chk("rx_extra_byte", 1, 0);
                else chk("rx_byte", r_sh, q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (tx_dv) begin
            dv_cnt++;
            held_byte = tx_byte;
            chk("tx_dv_one_cycle", dv_prev, 0);
        end
        if (tx_done_m) chk("tx_byte_stable", tx_byte, held_byte);
        if (send_done && !sd_prev) sd_rise++;
        dv_prev = tx_dv;
        sd_prev = send_done;
    end

    // simple byte-level model for the MEM_SIZE=1 instance
    int d1_t = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            d1_t <= 0; tx_done1 <= 1'b0;
        end else begin
            tx_done1 <= 1'b0;
            if (d1_t > 0) begin
                d1_t <= d1_t - 1;
                if (d1_t == 1) tx_done1 <= 1'b1;
            end else if (tx_dv1) begin
                d1_t <= 20;
                if (q1.size() == 0) chk("d1_extra_byte", 1, 0);
                else chk("d1_byte", tx_byte1, q1.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (tx_done_m) return;
        end
        chk("tx_done_timeout", 0, 1);
    endtask

    task automatic wait_send_done();
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            if (send_done) return;
        end
        chk("send_done_timeout", 0, 1);
    endtask

    task automatic push_mem0();
        for (int w = 0; w < 2; w++)
            for (int b = 0; b < 4; b++) q0.push_back(mem0[w][8*b +: 8]);
    endtask

    int base, sd_base;
    logic dv_seen;

    initial begin
        for (int i = 0; i < 256; i++) mem0[i] = 32'h0;
        mem0[0] = 32'h44332211;
        mem0[1] = 32'h88776655;
        mem1[0] = 32'hDEADBEEF;
        mem1[1] = 32'h0;

        cyc(3);
        chk("rst_tx_dv", tx_dv, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_send_done", send_done, 0);
        rst = 1'b0;
        cyc(3);

        // spurious tx_done in IDLE
        base = dv_cnt;
        inj_done = 1'b1; cyc(1); inj_done = 1'b0;
        cyc(10);
        chk("idle_spurious_dv", dv_cnt - base, 0);
        chk("idle_spurious_busy", busy, 0);

        // first transfer with latency checks
        push_mem0();
        base = dv_cnt;
        start = 1'b1;
        cyc(1);
        chk("lat_busy_set", busy, 1);
        chk("lat_addr0", mem_addr, 0);
        cyc(2);
        chk("lat_no_dv_early", dv_cnt - base, 0);
        cyc(1);
        chk("lat_first_dv", tx_dv, 1);
        chk("lat_first_byte", tx_byte, 8'h11);
        cyc(1);
        chk("lat_dv_drop", tx_dv, 0);
        wait_done();
        cyc(1);
        chk("lat_within_word", tx_dv, 1);
        wait_done();
        wait_done();
        wait_done();
        cyc(1);
        chk("lat_fetch_addr1", mem_addr, 1);
        dv_seen = tx_dv;
        cyc(1); dv_seen = dv_seen | tx_dv;
        cyc(1); dv_seen = dv_seen | tx_dv;
        chk("lat_cross_no_early_dv", dv_seen, 0);
        cyc(1);
        chk("lat_cross_word_dv", tx_dv, 1);
        chk("lat_cross_word_byte", tx_byte, 8'h55);
        wait_send_done();
        cyc(2);
        chk("t1_bytes", dv_cnt - base, 8);
        chk("t1_busy", busy, 0);
        chk("t1_send_done", send_done, 1);
        chk("t1_queue_empty", q0.size(), 0);

        // spurious tx_done in DONE
        base = dv_cnt;
        inj_done = 1'b1; cyc(1); inj_done = 1'b0;
        cyc(10);
        chk("done_spurious_dv", dv_cnt - base, 0);
        chk("done_spurious_sd", send_done, 1);

        // restart from DONE with coincident tx_done, start toggled mid-transfer
        start = 1'b0; cyc(2);
        push_mem0();
        base = dv_cnt;
        sd_base = sd_rise;
        start = 1'b1; inj_done = 1'b1;
        cyc(1);
        inj_done = 1'b0;
        chk("restart_sd_cleared", send_done, 0);
        chk("restart_busy", busy, 1);
        wait_done();
        cyc(20);
        start = 1'b0; cyc(5); start = 1'b1; cyc(5);
        wait_send_done();
        cyc(60);
        chk("t2_bytes", dv_cnt - base, 8);
        chk("t2_one_send_done", sd_rise - sd_base, 1);
        chk("t2_queue_empty", q0.size(), 0);

        // reset while waiting on the fifth byte
        start = 1'b0; cyc(2);
        push_mem0();
        start = 1'b1;
        repeat (4) wait_done();
        cyc(100);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx_dv", tx_dv, 0);
        chk("mid_rst_tx_byte", tx_byte, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_send_done", send_done, 0);
        q0.delete();
        cyc(5);
        base = dv_cnt;
        rst = 1'b0;
        cyc(30);
        chk("held_start_no_dv", dv_cnt - base, 0);
        chk("held_start_busy", busy, 0);
        start = 1'b0; cyc(2);
        push_mem0();
        start = 1'b1;
        wait_send_done();
        cyc(2);
        chk("t3_bytes", dv_cnt - base, 8);
        chk("t3_queue_empty", q0.size(), 0);

        // single-word instance
        q1.push_back(8'hEF); q1.push_back(8'hBE);
        q1.push_back(8'hAD); q1.push_back(8'hDE);
        start1 = 1'b1;
        for (int i = 0; i < 500 && !send_done1; i++) @(negedge clk);
        chk("d1_send_done", send_done1, 1);
        chk("d1_busy", busy1, 0);
        chk("d1_queue_empty", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_uart_tx.md
MEM_UART_TX -- requirements
Module: mem_uart_tx

Interface
REQ-001 Parameter MEM_SIZE, default 2: number of 32-bit words sent per transfer; legal range 1..2**ADDR_W.
REQ-002 Parameter ADDR_W, default 8: width of mem_addr.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  transfer request, level signal (driven from mem2uart); only a 0->1 transition is acted upon.
REQ-006 mem_addr  output  ADDR_W  word address to the result memory read port.
REQ-007 mem_rdata  input  32  read data; valid exactly one cycle after mem_addr is presented (synchronous read).
REQ-008 tx_dv  output  1  byte-valid strobe to uart_tx i_Tx_DV.
REQ-009 tx_byte  output  8  byte to uart_tx i_Tx_Byte.
REQ-010 tx_done  input  1  uart_tx o_Tx_Done, one-cycle pulse at end of stop bit.
REQ-011 busy  output  1  high while a transfer is in progress.
REQ-012 send_done  output  1  high after the last byte of a transfer completes.

Function
REQ-013 The block SHALL register start and detect a rising edge as start high with the registered value low.
REQ-014 In IDLE or DONE, a start edge SHALL begin a transfer: word index = 0, byte index = 0, send_done cleared, busy set, next state FETCH.
REQ-015 Start edges while busy SHALL be ignored.
REQ-016 States: IDLE, FETCH, WAIT_RD, LOAD, SEND, WAIT_TX, DONE.
REQ-017 FETCH: drive mem_addr = word index; next WAIT_RD (1 cycle).
REQ-018 WAIT_RD: hold mem_addr; next LOAD (1 cycle).
REQ-019 LOAD: latch mem_rdata into a 32-bit shift register; next SEND.
REQ-020 SEND: assert tx_dv for exactly one cycle with tx_byte = shift register [7:0] (LSB first); next WAIT_TX.
REQ-021 tx_byte SHALL remain stable from SEND until tx_done is sampled.
REQ-022 WAIT_TX: on tx_done, shift register right by 8 and increment byte index; if byte index was 3, increment word index and byte index wraps to 0.
REQ-023 After the WAIT_TX update: more bytes in word -> SEND; word finished and word index < MEM_SIZE -> FETCH; last word finished -> DONE.
REQ-024 Transfer order: word 0 byte[7:0], [15:8], [23:16], [31:24], then word 1, ...; total 4*MEM_SIZE bytes.
REQ-025 tx_done pulses seen outside WAIT_TX SHALL be ignored.
REQ-026 DONE: busy low, send_done high and held until the next accepted start edge or reset; mem_addr holds last value.
REQ-027 Word index SHALL be ADDR_W+1 bits wide so MEM_SIZE = 2**ADDR_W terminates correctly without wrap.
REQ-028 Latency: start edge registered -> first tx_dv SHALL be exactly 4 cycles (edge detect, FETCH, WAIT_RD, LOAD); tx_done -> next tx_dv SHALL be 1 cycle within a word, 4 cycles across words.
REQ-029 Simultaneous start edge and tx_done in DONE: start edge accepted, tx_done ignored.

Reset
REQ-030 On rst high, regardless of clk: state IDLE, tx_dv 0, tx_byte 0, mem_addr 0, busy 0, send_done 0, indices 0, shift register 0, registered start 0.
REQ-031 Reset mid-transfer SHALL abandon the transfer immediately; no further tx_dv until a new start edge after rst falls.
REQ-032 start held high through reset deassertion SHALL NOT trigger a transfer (registered start must see 0 first).

Verification
REQ-033 MEM_SIZE=2, mem = {0x44332211, 0x88776655}, start 0->1, uart_tx model with CLKS_PER_BIT=100 -> serial bytes 11 22 33 44 55 66 77 88 in order, then send_done=1, busy=0.
REQ-034 Cycle check: start edge -> tx_dv high exactly 4 cycles later for one cycle; tx_done -> next tx_dv 1 cycle later (byte 1) and 4 cycles later (byte 4, new word), mem_addr=1 in the preceding FETCH.
REQ-035 start toggled 1->0->1 during byte 2 -> ignored, still exactly 8 bytes, one send_done.
REQ-036 rst pulsed while waiting for byte 5 tx_done -> all outputs 0 within the same cycle; no further tx_dv; fresh start edge -> full 8-byte sequence from byte 11.
REQ-037 Spurious tx_done in IDLE and in DONE -> no tx_dv, state unchanged; second start edge after DONE -> send_done drops, 8 bytes resent.
REQ-038 MEM_SIZE=1, ADDR_W=1, mem[0]=0xDEADBEEF -> bytes EF BE AD DE, then send_done=1.
